// File: rtl/key_led_mode_ctrl.sv
// Key-burst mode controller: groups debounced key pulses into bursts, steps OFF/ON/SLOW/FAST, drives the LED.
// Optional build macro KEY_LED_MODE_MEMORY_EN: a long press remembers the mode, the next short press restores it.
module key_led_mode_ctrl #(
    parameter int SCLK_FREQ = 50_000_000,
    parameter int GAP_MS    = 350,
    parameter int LONG_CNT  = 2,
    parameter int SLOW_MS   = 500,
    parameter int FAST_MS   = 100
) (
    input  logic       sclk,
    input  logic       rst,
    input  logic       key_pulse,
    output logic       led,
    output logic [1:0] mode,
    output logic       busy
);
    localparam int TICK_DIV = SCLK_FREQ / 1000;
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GW       = $clog2(GAP_MS + 1);
    localparam int HALF_MAX = (SLOW_MS > FAST_MS) ? SLOW_MS : FAST_MS;
    localparam int BW       = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;

    localparam logic [1:0] M_OFF  = 2'd0;
    localparam logic [1:0] M_ON   = 2'd1;
    localparam logic [1:0] M_FAST = 2'd3;

    typedef enum logic [1:0] {IDLE, COLLECT, DECIDE} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   pre_cnt;
    logic            tick;
    logic [3:0]      pcnt, pcnt_nxt;
    logic [GW-1:0]   gap, gap_nxt;
    logic [1:0]      mode_nxt;
    logic            long_press;
    logic [BW-1:0]   blink_cnt, half_m1;
    logic            phase;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Free-running 1 ms prescaler
    always_ff @(posedge sclk) begin
        if (rst || tick) pre_cnt <= '0;
        else             pre_cnt <= pre_cnt + 1'b1;
    end

    assign tick       = (pre_cnt == PW'(TICK_DIV - 1));
    assign long_press = (pcnt >= 4'(LONG_CNT));

`ifdef KEY_LED_MODE_MEMORY_EN
    logic [1:0] mem;

    always_ff @(posedge sclk) begin
        if (rst)                                           mem <= M_OFF;
        else if (state == DECIDE && long_press && mode != M_OFF) mem <= mode;
    end
`endif

    always_comb begin
        state_nxt = state;
        pcnt_nxt  = pcnt;
        gap_nxt   = gap;
        mode_nxt  = mode;
        case (state)
            IDLE: begin
                if (key_pulse) begin
                    state_nxt = COLLECT;
                    pcnt_nxt  = 4'd1;
                    gap_nxt   = '0;
                end
            end
            COLLECT: begin
                // A pulse always restarts the silence window, even on a tick cycle
                if (key_pulse) begin
                    pcnt_nxt = sat_inc(pcnt);
                    gap_nxt  = '0;
                end else if (gap == GW'(GAP_MS)) begin
                    state_nxt = DECIDE;
                end else if (tick) begin
                    gap_nxt = gap + 1'b1;
                end
            end
            DECIDE: begin
                if (long_press)          mode_nxt = M_OFF;
`ifdef KEY_LED_MODE_MEMORY_EN
                else if (mode == M_OFF)  mode_nxt = (mem != M_OFF) ? mem : M_ON;
`endif
                else                     mode_nxt = mode + 2'd1;
                gap_nxt = '0;
                if (key_pulse) begin
                    state_nxt = COLLECT;
                    pcnt_nxt  = 4'd1;
                end else begin
                    state_nxt = IDLE;
                    pcnt_nxt  = 4'd0;
                end
            end
            default: begin
                state_nxt = IDLE;
                pcnt_nxt  = 4'd0;
                gap_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state <= IDLE;
            pcnt  <= 4'd0;
            gap   <= '0;
            mode  <= M_OFF;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            pcnt  <= pcnt_nxt;
            gap   <= gap_nxt;
            mode  <= mode_nxt;
            busy  <= (state_nxt != IDLE);
        end
    end

    assign half_m1 = (mode == M_FAST) ? BW'(FAST_MS - 1) : BW'(SLOW_MS - 1);

    // A mode change restarts the blink so blink modes always begin lit
    always_ff @(posedge sclk) begin
        if (rst) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (mode_nxt != mode) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (tick) begin
            if (blink_cnt == half_m1) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            led <= 1'b0;
        end else begin
            case (mode)
                M_OFF:   led <= 1'b0;
                M_ON:    led <= 1'b1;
                default: led <= phase;
            endcase
        end
    end
endmodule

// File: tb/tb_key_led_mode_ctrl.sv
// Self-checking bench for key_led_mode_ctrl against a timeline-based reference model.
module tb_key_led_mode_ctrl;
    localparam int DIV = 10, GAP = 5, LONGC = 2, SLOW = 4, FAST = 2;
`ifdef KEY_LED_MODE_MEMORY_EN
    localparam bit MEM_EN = 1'b1;
`else
    localparam bit MEM_EN = 1'b0;
`endif

    logic       sclk = 1'b0;
    logic       rst = 1'b1;
    logic       key_pulse = 1'b0;
    logic       led;
    logic [1:0] mode;
    logic       busy;
    logic [3:0] obs;
    int total = 0;
    int bad = 0;

    key_led_mode_ctrl #(
        .SCLK_FREQ(DIV * 1000), .GAP_MS(GAP), .LONG_CNT(LONGC), .SLOW_MS(SLOW), .FAST_MS(FAST)
    ) dut (
        .sclk(sclk), .rst(rst), .key_pulse(key_pulse), .led(led), .mode(mode), .busy(busy)
    );

    always #5 sclk = ~sclk;
    assign obs = {led, mode, busy};

    // Reference model: decisions are scheduled as absolute cycle deadlines, blink phase
    // is derived from the number of ms ticks elapsed since the last mode change.
    int m_cyc = 0, m_cnt = 0, m_need = 0, m_decide = -1, m_blink = 0, m_mode = 0, m_mem = 0, m_nm = 0;
    bit m_active = 0, m_tk = 0, e_led = 0;
    logic [3:0] m_exp = 4'b0;

    function automatic int half_of(input int md);
        return (md == 3) ? FAST : SLOW;
    endfunction

    always @(posedge sclk) begin
        if (rst) begin
            m_cyc = 0; m_cnt = 0; m_need = 0; m_decide = -1; m_blink = 0;
            m_mode = 0; m_mem = 0; m_active = 0; e_led = 0;
        end else begin
            m_tk  = (m_cyc % DIV) == DIV - 1;
            e_led = (m_mode == 0) ? 1'b0 : (m_mode == 1) ? 1'b1 :
                    (((m_blink / half_of(m_mode)) % 2) == 0);
            m_nm = m_mode;
            if (m_cyc == m_decide) begin
                if (m_cnt >= LONGC) begin
                    if (MEM_EN && m_mode != 0) m_mem = m_mode;
                    m_nm = 0;
                end else if (m_mode == 0) begin
                    m_nm = (MEM_EN && m_mem != 0) ? m_mem : 1;
                end else begin
                    m_nm = (m_mode + 1) % 4;
                end
                m_decide = -1;
                if (key_pulse) begin m_cnt = 1; m_need = GAP; end
                else m_active = 0;
            end else if (key_pulse) begin
                m_cnt    = m_active ? ((m_cnt < 15) ? m_cnt + 1 : 15) : 1;
                m_active = 1;
                m_need   = GAP;
                m_decide = -1;
            end else if (m_active && m_decide < 0 && m_tk) begin
                m_need--;
                if (m_need == 0) m_decide = m_cyc + 2;
            end
            if (m_nm != m_mode) m_blink = 0;
            else if (m_tk)      m_blink++;
            m_mode = m_nm;
            m_cyc++;
        end
        m_exp = {e_led, 2'(m_mode), m_active};
    end

    task automatic clk_step(input bit kp);
        key_pulse = kp;
        @(posedge sclk);
        @(negedge sclk);
        key_pulse = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clk_step(1'b0);
            total++;
            if (obs !== 4'b0) begin bad++; $display("FAIL reset_hold got %b want 0000", obs); end
        end
        rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            clk_step(1'b0);
            total++;
            if (obs !== 4'b0) begin bad++; $display("FAIL reset_idle i=%0d got %b want 0000", i, obs); end
        end
    endtask

    task automatic test_single_pulse();
        int busy_n;
        logic [1:0] pm;
        clk_step(1'b1);
        busy_n = (busy === 1'b1) ? 1 : 0;
        pm = mode;
        for (int i = 0; i < 80; i++) begin
            clk_step(1'b0);
            total++;
            if (obs !== m_exp) begin bad++; $display("FAIL single cyc=%0d got %b want %b", m_cyc, obs, m_exp); end
            if (busy === 1'b1) busy_n++;
            if (mode === 2'd1 && pm === 2'd0) begin
                total++;
                if (led !== 1'b0) begin bad++; $display("FAIL led_lag got %b want 0", led); end
            end
            pm = mode;
        end
        total++;
        if (mode !== 2'd1 || led !== 1'b1) begin
            bad++; $display("FAIL single_end got mode=%0d led=%b want mode=1 led=1", mode, led);
        end
        total++;
        if (busy_n < 43 || busy_n > 52) begin
            bad++; $display("FAIL busy_len got %0d want 43..52", busy_n);
        end
    endtask

    task automatic test_blink();
        int want_m, want_iv, last, stable;
        logic pl;
        for (int k = 0; k < 2; k++) begin
            want_m  = 2 + k;
            want_iv = (k == 0) ? 40 : 20;
            last    = -1;
            stable  = 0;
            clk_step(1'b1);
            pl = led;
            for (int i = 0; i < 200; i++) begin
                clk_step(1'b0);
                total++;
                if (obs !== m_exp) begin bad++; $display("FAIL blink cyc=%0d got %b want %b", m_cyc, obs, m_exp); end
                if (mode === 2'(want_m)) stable++; else stable = 0;
                if (stable >= 3 && led !== pl) begin
                    if (last >= 0) begin
                        total++;
                        if (i - last != want_iv) begin
                            bad++; $display("FAIL blink_period mode=%0d got %0d want %0d", want_m, i - last, want_iv);
                        end
                    end
                    last = i;
                end
                pl = led;
            end
            total++;
            if (mode !== 2'(want_m)) begin bad++; $display("FAIL blink_mode got %0d want %0d", mode, want_m); end
        end
        clk_step(1'b1);
        for (int i = 0; i < 70; i++) begin
            clk_step(1'b0);
            total++;
            if (obs !== m_exp) begin bad++; $display("FAIL wrap cyc=%0d got %b want %b", m_cyc, obs, m_exp); end
        end
        total++;
        if (mode !== 2'd0 || led !== 1'b0) begin bad++; $display("FAIL wrap_off got mode=%0d led=%b want 0/0", mode, led); end
    endtask

    task automatic test_long_press();
        int np, want;
        for (int s = 0; s < 6; s++) begin
            // short, short, long, short, long, long (the last one while already OFF)
            np = (s == 2 || s >= 4) ? 3 : 1;
            for (int i = 0; i < 30 * np + 70; i++) begin
                clk_step((i % 30 == 0) && (i < 30 * np));
                total++;
                if (obs !== m_exp) begin bad++; $display("FAIL long s=%0d cyc=%0d got %b want %b", s, m_cyc, obs, m_exp); end
                if (s == 5) begin
                    total++;
                    if (mode !== 2'd0 || led !== 1'b0) begin
                        bad++; $display("FAIL off_repeat got mode=%0d led=%b want 0/0", mode, led);
                    end
                end
            end
            case (s)
                1:       want = 2;
                3:       want = MEM_EN ? 2 : 1;
                default: want = (s == 0) ? 1 : 0;
            endcase
            total++;
            if (mode !== 2'(want) || (want == 0 && led !== 1'b0)) begin
                bad++; $display("FAIL long_step s=%0d got mode=%0d led=%b want mode=%0d", s, mode, led, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit found = 0;
        clk_step(1'b1);
        for (int i = 0; i < 100 && !found; i++) begin
            if (m_decide == m_cyc) begin
                clk_step(1'b1);
                found = 1;
                total++;
                if (busy !== 1'b1 || mode !== (MEM_EN ? 2'd2 : 2'd1)) begin
                    bad++; $display("FAIL b2b_first got busy=%b mode=%0d want busy=1 mode=%0d", busy, mode, MEM_EN ? 2 : 1);
                end
            end else begin
                clk_step(1'b0);
                total++;
                if (obs !== m_exp) begin bad++; $display("FAIL b2b cyc=%0d got %b want %b", m_cyc, obs, m_exp); end
            end
        end
        if (!found) begin total++; bad++; $display("FAIL b2b_timeout got no decision want one within 100 cycles"); end
        for (int i = 0; i < 70; i++) begin
            clk_step(1'b0);
            total++;
            if (obs !== m_exp) begin bad++; $display("FAIL b2b_tail cyc=%0d got %b want %b", m_cyc, obs, m_exp); end
        end
        total++;
        if (mode !== (MEM_EN ? 2'd3 : 2'd2)) begin
            bad++; $display("FAIL b2b_second got %0d want %0d", mode, MEM_EN ? 3 : 2);
        end
    endtask

    task automatic test_reset_mid();
        clk_step(1'b1);
        for (int i = 0; i < 10; i++) clk_step(1'b0);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got %b want 1", busy); end
        rst = 1'b1;
        clk_step(1'b0);
        rst = 1'b0;
        total++;
        if (obs !== 4'b0) begin bad++; $display("FAIL mid_rst got %b want 0000", obs); end
        for (int i = 0; i < 80; i++) begin
            clk_step(1'b0);
            total++;
            if (obs !== 4'b0) begin bad++; $display("FAIL mid_after i=%0d got %b want 0000", i, obs); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            clk_step($urandom_range(0, 39) == 0);
            total++;
            if (obs !== m_exp) begin bad++; $display("FAIL random cyc=%0d got %b want %b", m_cyc, obs, m_exp); end
        end
    endtask

    initial begin
        @(negedge sclk);
        test_reset();
        test_single_pulse();
        test_blink();
        test_long_press();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
